// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel gradient / NMS chain.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
// Contents: direction codes, default Q8 tangent thresholds, unsigned saturation helper.
package sobel_pkg;

  // Quantised gradient direction codes consumed by non-maximum suppression.
  localparam logic [1:0] DIR_N  = 2'b00;
  localparam logic [1:0] DIR_E  = 2'b01;
  localparam logic [1:0] DIR_NW = 2'b10;
  localparam logic [1:0] DIR_NE = 2'b11;

  // tan(22.5 deg) and tan(67.5 deg) scaled by 256.
  localparam int TAN_LO_DEF = 106;
  localparam int TAN_HI_DEF = 618;

  // Clamp an unsigned value to the largest number representable in 'width' bits.
  function automatic logic [63:0] sat_u(input logic [63:0] value, input int width);
    logic [63:0] lim;
    if (width >= 64) return value;
    lim = (64'd1 << width) - 64'd1;
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/sobel_dir_quant.sv
// Quantises a gradient vector into one of four directions using Q8 tangent compares.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: ax/ay = |gx|/|gy|, sgx/sgy = sign bits of gx/gy, dir = N/E/NW/NE code.
module sobel_dir_quant
  import sobel_pkg::*;
#(
  parameter int AW     = 10,
  parameter int TAN_LO = TAN_LO_DEF,
  parameter int TAN_HI = TAN_HI_DEF
) (
  input  logic [AW-1:0] ax,
  input  logic [AW-1:0] ay,
  input  logic          sgx,
  input  logic          sgy,
  output logic [1:0]    dir
);

  // Room for ay<<8 and for ax times a threshold of up to 12 bits.
  localparam int PW = AW + 12;

  logic [PW-1:0] ay_q8;
  logic [PW-1:0] lo_lim;
  logic [PW-1:0] hi_lim;

  always_comb begin
    ay_q8  = PW'(ay) << 8;
    lo_lim = PW'(ax) * PW'(TAN_LO);
    hi_lim = PW'(ax) * PW'(TAN_HI);
    // Strict compares: a tie on either threshold falls into the diagonal band.
    if ((ax == '0) && (ay == '0)) dir = DIR_E;
    else if (ay_q8 < lo_lim)      dir = DIR_E;
    else if (ay_q8 > hi_lim)      dir = DIR_N;
    else if (sgx == sgy)          dir = DIR_NE;
    else                          dir = DIR_NW;
  end

endmodule

// File: rtl/sobel_grad_dir_pipe.sv
// Sobel gradient stage: 3x3 window in, magnitude (L1 or squared L2) and 2-bit direction out.
// Latency: 3 cycles when unstalled, one beat per cycle.
// Backpressure: every stage advances on adv = ~m_valid | m_ready; s_ready = adv.
// Ports: clk, rst_n, mag_mode; s_valid/s_ready/s_sof/s_win (p11 in LSBs, p33 in MSBs);
//        m_valid/m_ready/m_mag/m_dir/m_sof/m_eol. Image-border pixels output mag 0, dir E.
module sobel_grad_dir_pipe
  import sobel_pkg::*;
#(
  parameter int DW     = 8,
  parameter int IMG_W  = 510,
  parameter int IMG_H  = 636,
  parameter int OUT_W  = 24,
  parameter int TAN_LO = TAN_LO_DEF,
  parameter int TAN_HI = TAN_HI_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mag_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [9*DW-1:0]   s_win,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_mag,
  output logic [1:0]        m_dir,
  output logic              m_sof,
  output logic              m_eol
);

  localparam int GW = DW + 3;          // signed gradient
  localparam int AW = DW + 2;          // gradient magnitude per axis
  localparam int MW = 2 * AW + 1;      // wide enough for ax^2 + ay^2
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic adv;
  logic s_fire;

  assign adv     = ~m_valid | m_ready;
  assign s_ready = adv;
  assign s_fire  = s_valid & s_ready;

  // ---------------- stage 1: gradients and frame position ----------------
  logic [DW-1:0]        p [9];
  logic signed [GW-1:0] gx_c, gy_c;
  logic [CW-1:0]        col_q, cur_col;
  logic [RW-1:0]        row_q, cur_row;
  logic                 border_c, eol_c;

  function automatic logic signed [GW-1:0] px(input logic [DW-1:0] v);
    return signed'(GW'(v));
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) p[i] = s_win[i*DW +: DW];
    gx_c = (px(p[2]) + (px(p[5]) <<< 1) + px(p[8])) - (px(p[0]) + (px(p[3]) <<< 1) + px(p[6]));
    gy_c = (px(p[0]) + (px(p[1]) <<< 1) + px(p[2])) - (px(p[6]) + (px(p[7]) <<< 1) + px(p[8]));
  end

  // A start-of-frame beat is position (0,0) regardless of where the counters were.
  assign cur_col  = s_sof ? '0 : col_q;
  assign cur_row  = s_sof ? '0 : row_q;
  assign eol_c    = (cur_col == CW'(IMG_W - 1));
  assign border_c = (cur_col == '0) | eol_c | (cur_row == '0) | (cur_row == RW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (s_fire) begin
      if (eol_c) begin
        col_q <= '0;
        row_q <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
    end
  end

  logic                 s1_vld, s1_mode, s1_border, s1_sof, s1_eol;
  logic signed [GW-1:0] s1_gx, s1_gy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_mode   <= 1'b0;
      s1_border <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s1_gx     <= '0;
      s1_gy     <= '0;
    end else if (adv) begin
      s1_vld    <= s_valid;
      s1_mode   <= mag_mode;
      s1_border <= border_c;
      s1_sof    <= s_valid & s_sof;
      s1_eol    <= s_valid & eol_c;
      s1_gx     <= gx_c;
      s1_gy     <= gy_c;
    end
  end

  // ---------------- stage 2: magnitude and direction ----------------
  logic [AW-1:0] ax_c, ay_c;
  logic [MW-1:0] mag_c;
  logic [1:0]    dir_c;

  always_comb begin
    ax_c  = AW'(s1_gx[GW-1] ? -s1_gx : s1_gx);
    ay_c  = AW'(s1_gy[GW-1] ? -s1_gy : s1_gy);
    mag_c = s1_mode ? (MW'(ax_c) * MW'(ax_c) + MW'(ay_c) * MW'(ay_c))
                    : (MW'(ax_c) + MW'(ay_c));
  end

  sobel_dir_quant #(
    .AW     (AW),
    .TAN_LO (TAN_LO),
    .TAN_HI (TAN_HI)
  ) u_dir (
    .ax  (ax_c),
    .ay  (ay_c),
    .sgx (s1_gx[GW-1]),
    .sgy (s1_gy[GW-1]),
    .dir (dir_c)
  );

  logic          s2_vld, s2_border, s2_sof, s2_eol;
  logic [MW-1:0] s2_mag;
  logic [1:0]    s2_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      s2_border <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eol    <= 1'b0;
      s2_mag    <= '0;
      s2_dir    <= DIR_E;
    end else if (adv) begin
      s2_vld    <= s1_vld;
      s2_border <= s1_border;
      s2_sof    <= s1_sof;
      s2_eol    <= s1_eol;
      s2_mag    <= mag_c;
      s2_dir    <= dir_c;
    end
  end

  // ---------------- stage 3: border forcing, saturation, output ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_mag   <= '0;
      m_dir   <= 2'b00;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (adv) begin
      m_valid <= s2_vld;
      m_mag   <= s2_border ? '0 : OUT_W'(sat_u(64'(s2_mag), OUT_W));
      m_dir   <= s2_border ? DIR_E : s2_dir;
      m_sof   <= s2_sof;
      m_eol   <= s2_eol;
    end
  end

endmodule
